// File: rtl/if_unit_pkg.sv
// Shared constants and types for the instruction-fetch unit and its fetch buffer.
package if_unit_pkg;

    localparam int WORD_W = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W = 2;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t PC_STEP = 32'd4;
    localparam word_t RESET_PC_DEFAULT = 32'h0000_3000;

    // One buffered fetch: byte address and the instruction word read from it.
    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of {pc, instr} pairs between fetch and decode.
// Flush wins over push and pop; push while full is accepted only with a pop.
module fetch_fifo
    import if_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  fetch_entry_t       wdata_i,
    output fetch_entry_t       rdata_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    fetch_entry_t     mem_q [FIFO_DEPTH];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign pop_ok  = pop_i && (count_q != '0) && !flush_i;
    assign push_ok = push_i && ((count_q != FULL_CNT) || pop_ok) && !flush_i;

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = ~wr_ptr_q;
            if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is reset on purpose: the head entry is visible on out_pc/out_instr and must read zero in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_unit.sv
// Instruction-fetch unit: registered fetch PC feeding instruction memory,
// a two-entry fetch buffer toward decode, and redirect handling that flushes it.
module if_unit
    import if_unit_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic [WORD_W-1:0] im_addr,
    input  logic [WORD_W-1:0] im_data,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_instr,
    output logic [WORD_W-1:0] out_pc
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    word_t            fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] count;
    logic             push, pop;
    fetch_entry_t     push_entry, head_entry;

    // A redirect hides the head and blocks both transfers in the cycle it is seen.
    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = !redirect_valid && ((count != FULL_CNT) || pop);

    assign push_entry = '{pc: fetch_pc_q, instr: im_data};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~(PC_STEP - 1'b1);
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo u_fetch_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (count)
    );

    assign im_addr   = fetch_pc_q;
    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;

endmodule

// File: tb/tb_if_unit.sv
// Self-checking bench for if_unit: expected {pc, instr} pairs are queued as
// stimulus is applied and popped as the unit presents instructions to decode.
module tb_if_unit;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word returned is the address scrambled by a fixed key.
    assign im_data = im_addr ^ XOR_KEY;

    if_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk            (clk),
        .reset          (reset),
        .im_addr        (im_addr),
        .im_data        (im_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = pc ^ XOR_KEY;
        exp_q.push_back(e);
    endtask

    task automatic hold_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || im_addr !== 32'h3000 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b im_addr=%h pc=%h instr=%h, required 0/00003000/0/0",
                     out_valid, im_addr, out_pc, out_instr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || im_addr !== 32'h3000) begin
            errors++;
            $display("FAIL reset_held: valid=%b im_addr=%h, required 0/00003000", out_valid, im_addr);
        end
    endtask

    task automatic test_stream();
        exp_t e;
        reset     = 1'b0;
        out_ready = 1'b1;
        expect_pc(32'h3000);
        expect_pc(32'h3004);
        expect_pc(32'h3008);
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
                errors++;
                $display("FAIL stream: valid=%b pc=%h instr=%h, required 1/%h/%h",
                         out_valid, out_pc, out_instr, e.pc, e.instr);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        hold_reset();
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k >= 2) begin
                checks++;
                if (dut.count !== 2'd2 || im_addr !== 32'h3008 || out_valid !== 1'b1 ||
                    out_pc !== 32'h3000 || out_instr !== (32'h3000 ^ XOR_KEY)) begin
                    errors++;
                    $display("FAIL backpressure_hold: cycle=%0d count=%0d im_addr=%h valid=%b pc=%h instr=%h, required 2/00003008/1/00003000/%h",
                             k, dut.count, im_addr, out_valid, out_pc, out_instr, 32'h3000 ^ XOR_KEY);
                end
            end
        end
        out_ready = 1'b1;
        expect_pc(32'h3000);
        expect_pc(32'h3004);
        expect_pc(32'h3008);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
                errors++;
                $display("FAIL backpressure_drain: valid=%b pc=%h instr=%h, required 1/%h/%h",
                         out_valid, out_pc, out_instr, e.pc, e.instr);
            end
            tick();
        end
    endtask

    task automatic test_redirect_full();
        exp_t e;
        hold_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (dut.count !== 2'd2) begin
            errors++;
            $display("FAIL redirect_full_setup: count=%0d, required 2", dut.count);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3403;
        out_ready      = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_cycle_valid: valid=%b, required 0", out_valid);
        end
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || im_addr !== 32'h3400) begin
            errors++;
            $display("FAIL redirect_next: valid=%b im_addr=%h, required 0/00003400", out_valid, im_addr);
        end
        expect_pc(32'h3400);
        expect_pc(32'h3404);
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
                errors++;
                $display("FAIL redirect_target: valid=%b pc=%h instr=%h, required 1/%h/%h",
                         out_valid, out_pc, out_instr, e.pc, e.instr);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        expect_pc(32'hFFFF_FFF8);
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
                errors++;
                $display("FAIL wrap: valid=%b pc=%h instr=%h, required 1/%h/%h",
                         out_valid, out_pc, out_instr, e.pc, e.instr);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4000;
        tick();
        redirect_pc    = 32'h0000_5000;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || im_addr !== 32'h5000) begin
            errors++;
            $display("FAIL back_to_back_load: valid=%b im_addr=%h, required 0/00005000", out_valid, im_addr);
        end
        expect_pc(32'h5000);
        expect_pc(32'h5004);
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
                errors++;
                $display("FAIL back_to_back: valid=%b pc=%h instr=%h, required 1/%h/%h",
                         out_valid, out_pc, out_instr, e.pc, e.instr);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (dut.count !== 2'd2) begin
            errors++;
            $display("FAIL async_reset_setup: count=%0d, required 2", dut.count);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || im_addr !== 32'h3000 || out_pc !== 32'h0 ||
            out_instr !== 32'h0 || dut.count !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_now: valid=%b im_addr=%h pc=%h instr=%h count=%0d, required 0/00003000/0/0/0",
                     out_valid, im_addr, out_pc, out_instr, dut.count);
        end
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        expect_pc(32'h3000);
        expect_pc(32'h3004);
        expect_pc(32'h3008);
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
                errors++;
                $display("FAIL async_reset_restart: valid=%b pc=%h instr=%h, required 1/%h/%h",
                         out_valid, out_pc, out_instr, e.pc, e.instr);
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
